sysmmu_axi_mem_responder: RTL and testbench
===========================================

// Module: sysmmu_axi_mem_responder
// PURPOSE
//  AXI4 slave memory responder: the responder end of the master port that sysmmu_segment issues toward DDR4.
//  Replaces the DDR4 MC plus memory model on short sims and bring-up, backed by an on-chip synchronous RAM.
//  Serves INCR/FIXED bursts on independent read and write channels and returns range/size errors as SLVERR.
// PARAMETERS
//  ADDR_WIDTH   32  AXI address width
//  DATA_WIDTH   64  AXI data width, power of 2, >= 32
//  ID_WIDTH     4   AXI ID width
//  MEM_AW       10  log2 of RAM depth in beats
//  BASE_ADDR    0   byte address of RAM word 0; window = BASE_ADDR .. BASE_ADDR + 2^MEM_AW*DATA_WIDTH/8 - 1
// PORTS
//  clk         in   1            single clock
//  sys_rst     in   1            synchronous, active-high reset
//  s_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address
//  s_awvalid   in   1            |  s_awready  out  1
//  s_wdata     in   DATA_WIDTH   |  s_wstrb    in   DATA_WIDTH/8
//  s_wlast     in   1            |  s_wvalid   in   1   |  s_wready  out  1
//  s_bid       out  ID_WIDTH     |  s_bresp    out  2   |  s_bvalid  out  1  |  s_bready  in  1
//  s_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address
//  s_arvalid   in   1            |  s_arready  out  1
//  s_rid       out  ID_WIDTH     |  s_rdata    out  DATA_WIDTH
//  s_rresp     out  2            |  s_rlast    out  1   |  s_rvalid  out  1  |  s_rready  in  1
//  err_cnt     out  16           count of SLVERR responses plus wlast mismatches; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, s_bresp = s_rresp = 0, s_rdata = 0, s_rlast = 0, err_cnt = 0, both FSMs idle.
//   RAM contents are not cleared.
//  Write FSM (W_IDLE, W_DATA, W_RESP):
//   W_IDLE:
//    - s_awready = 1.
//    - On AW handshake: latch id, beat address (awaddr with low log2(DATA_WIDTH/8) bits cleared), len, burst.
//    - Clear err flag; go to W_DATA.
//   W_DATA:
//    - s_wready = 1.
//    - Each W handshake writes byte lanes where wstrb = 1 when the beat address is in the window.
//    - Beat outside the window: write dropped, err flag set.
//    - INCR: address += DATA_WIDTH/8 per beat. FIXED: address held.
//    - Beat counter runs 0..awlen. After beat awlen, go to W_RESP.
//    - wlast = 1 before beat awlen, or wlast = 0 on beat awlen: err flag set and err_cnt += 1 (mismatch).
//      Beat count still governs the burst.
//   W_RESP:
//    - s_bvalid = 1, s_bid = latched id, s_bresp = err ? 2'b10 : 2'b00.
//    - Held stable until s_bready; then go to W_IDLE. s_bvalid falls the cycle after the handshake.
//  Read FSM (R_IDLE, R_FETCH, R_DATA):
//   R_IDLE:
//    - s_arready = 1.
//    - On AR handshake: latch as for writes; go to R_FETCH.
//   R_FETCH:
//    - Drive RAM address; go to R_DATA next cycle with RAM data registered into s_rdata.
//   R_DATA:
//    - s_rvalid = 1.
//    - s_rdata, s_rresp, s_rid, s_rlast held stable until s_rready.
//    - Out-of-window beat: rdata = 0, rresp = 2'b10.
//    - s_rlast = 1 on beat arlen.
//    - Handshake: last beat -> R_IDLE, else advance address -> R_FETCH.
//   Throughput 1 beat per 2 cycles. First rvalid 2 cycles after the AR handshake cycle.
//  Illegal bursts: awsize/arsize != log2(DATA_WIDTH/8), or burst = WRAP/2'b11.
//   - Whole burst is SLVERR: no RAM writes; all read beats rdata = 0, rresp = 2'b10.
//   - Full beat count still honoured.
//  err_cnt: +1 per B with SLVERR, +1 per R beat with SLVERR, +1 per wlast mismatch.
//   Simultaneous events in one cycle add their sum (max 3), saturating.
//  Read and write are independent. Same-cycle RAM write and read of one word returns OLD data (read-first).
//  Address wrap: a beat address that overflows ADDR_WIDTH wraps modulo 2^ADDR_WIDTH and is range-checked as wrapped.
//  Reset mid-burst: FSMs return to idle next cycle, no B/R issued for the aborted burst, err_cnt = 0.
// TESTING
//  1. AW addr=0x40 len=3 INCR size=3, 4 W beats D0..D3 all strb; AR same
//     -> B OKAY after beat 3; R returns D0..D3, rlast on 4th beat, rresp 0.
//  2. Write 0xFFFF_FFFF_FFFF_FFFF, then write 0x11 with wstrb=8'h01 to the same address, read
//     -> 0xFFFF_FFFF_FFFF_FF11.
//  3. AW at last window word, len=1 -> bresp 2'b10, word 0 of the window unchanged.
//     AR same -> beat0 real data with OKAY, beat1 zero with SLVERR; err_cnt = 2.
//  4. Hold s_rready=0 for 10 cycles on beat 0 -> rvalid/rdata/rlast stable throughout; no beat lost or duplicated.
//  5. awlen=2 with wlast on beat 1 -> 3 beats still accepted, bresp 2'b10, err_cnt += 2.
//  6. Assert sys_rst during beat 2 of a len=7 read -> rvalid=0 next cycle; new AR served normally after release.

Source files
------------

// File: rtl/sysmmu_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// sysmmu_axi_mem_responder
//
// AXI4 slave memory responder backed by an on-chip synchronous RAM. It stands
// in for the DDR4 controller and memory model on the master port that
// sysmmu_segment drives, for short simulations and bring-up.
//
// Read and write channels are served by two independent FSMs. INCR and FIXED
// bursts are supported. Beats outside the RAM window, wrong beat sizes and
// WRAP/reserved burst types are answered with SLVERR.
//
// Ports
//   clk, sys_rst                         single clock, synchronous active-high reset
//   s_aw* / s_awvalid / s_awready        write address channel
//   s_wdata/wstrb/wlast/wvalid/wready    write data channel
//   s_bid/bresp/bvalid/bready            write response channel
//   s_ar* / s_arvalid / s_arready        read address channel
//   s_rid/rdata/rresp/rlast/rvalid/rready read data channel
//   err_cnt                              saturating count of SLVERR responses
//                                        plus wlast mismatches
// -----------------------------------------------------------------------------
module sysmmu_axi_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    // write address
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    // write response
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    // read address
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    // read data
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    // status
    output logic [15:0]             err_cnt
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(STRB_W);
    localparam int WIN_SHIFT = MEM_AW + OFF_W;

    localparam logic [2:0]            LEGAL_SIZE  = 3'(OFF_W);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC    = ADDR_WIDTH'(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [1:0]            BURST_INCR  = 2'b01;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    // Window check on the wrapped offset: subtracting the base modulo
    // 2^ADDR_WIDTH means any address below BASE_ADDR becomes a huge offset
    // and fails the check, with no separate lower-bound compare.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (off >> WIN_SHIFT) == '0;
    endfunction

    function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return MEM_AW'(off >> OFF_W);
    endfunction

    // Burst is illegal when the beat size is not the full bus width or the
    // burst type is WRAP / reserved (bit 1 set).
    function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst);
        return (size != LEGAL_SIZE) || burst[1];
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    // RAM
    // NOTE: the RAM array has no reset; clearing it would turn a block RAM into
    // thousands of flops. Only the control and output registers are reset.
    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    // Write channel state
    w_state_e              w_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_beat_q;
    logic [1:0]            w_burst_q;
    logic                  w_bad_q;
    logic                  w_err_q;

    // Read channel state
    r_state_e              r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q;
    logic [7:0]            r_beat_q;
    logic [1:0]            r_burst_q;
    logic                  r_bad_q;

    logic [15:0]           err_cnt_q;
    logic [15:0]           err_cnt_d;
    logic [17:0]           err_sum;

    // Write datapath decode
    logic              w_hs;
    logic              w_is_last;
    logic              w_mismatch;
    logic              w_beat_ok;
    logic              w_err_d;
    logic              mem_we;
    logic [MEM_AW-1:0] w_idx;

    // Read datapath decode
    logic              r_hs;
    logic              r_beat_ok;
    logic [MEM_AW-1:0] r_idx;

    logic              b_err;
    logic              r_err;

    always_comb begin
        w_hs       = wready_q && s_wvalid;
        w_is_last  = (w_beat_q == w_len_q);
        // wlast must be asserted exactly on the beat the counter says is last
        w_mismatch = w_hs && (s_wlast != w_is_last);
        w_beat_ok  = !w_bad_q && in_window(w_addr_q);
        w_err_d    = w_err_q || (w_hs && (!w_beat_ok || w_mismatch));
        mem_we     = w_hs && w_beat_ok;
        w_idx      = word_index(w_addr_q);

        r_hs       = rvalid_q && s_rready;
        r_beat_ok  = !r_bad_q && in_window(r_addr_q);
        r_idx      = word_index(r_addr_q);

        b_err      = bvalid_q && s_bready && bresp_q[1];
        r_err      = r_hs && rresp_q[1];
    end

    // Write FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the same block win, which
    // is relied on where a default is overridden by a handshake.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_awvalid && awready_q) begin
                        bid_q     <= s_awid;
                        w_addr_q  <= s_awaddr & ALIGN_MASK;
                        w_len_q   <= s_awlen;
                        w_burst_q <= s_awburst;
                        w_bad_q   <= burst_illegal(s_awsize, s_awburst);
                        w_beat_q  <= '0;
                        w_err_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_err_q <= w_err_d;
                        // The beat counter, not wlast, terminates the burst
                        if (w_is_last) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_err_d ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                            if (w_burst_q == BURST_INCR) begin
                                w_addr_q <= w_addr_q + BEAT_INC;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port with per-byte enables
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM. The RAM read in R_FETCH lands directly in the R-channel data
    // register; since the write port updates with non-blocking semantics, a
    // same-cycle write to the fetched word returns the old contents.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_arvalid && arready_q) begin
                        rid_q     <= s_arid;
                        r_addr_q  <= s_araddr & ALIGN_MASK;
                        r_len_q   <= s_arlen;
                        r_burst_q <= s_arburst;
                        r_bad_q   <= burst_illegal(s_arsize, s_arburst);
                        r_beat_q  <= '0;
                        arready_q <= 1'b0;
                        r_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_q   <= r_beat_ok ? mem[r_idx] : '0;
                    rresp_q   <= r_beat_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_q   <= (r_beat_q == r_len_q);
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (s_rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_beat_q <= r_beat_q + 8'd1;
                            if (r_burst_q == BURST_INCR) begin
                                r_addr_q <= r_addr_q + BEAT_INC;
                            end
                            r_state_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Error counter: up to three events can land in one cycle (B SLVERR,
    // R SLVERR, wlast mismatch); their sum is added and clamped.
    always_comb begin
        err_sum   = {2'b00, err_cnt_q} + 18'(b_err) + 18'(r_err) + 18'(w_mismatch);
        err_cnt_d = (err_sum > 18'h0FFFF) ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_bid     = bid_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rid     = rid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sysmmu_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sysmmu_axi_mem_responder
//
// Self-checking bench for sysmmu_axi_mem_responder (64-bit data, 1024-word
// window at address 0). A byte-accurate memory model predicts every B and R
// response; predictions are pushed to scoreboard queues when a burst is
// issued and popped when the DUT presents the response.
// -----------------------------------------------------------------------------
module tb_sysmmu_axi_mem_responder;

    localparam int          TMO     = 64;
    localparam logic [31:0] WIN_END = 32'h0000_2000;
    localparam logic [1:0]  FIXED   = 2'b00;
    localparam logic [1:0]  INCR    = 2'b01;
    localparam logic [1:0]  WRAP    = 2'b10;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid;
    logic        s_awready;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wvalid;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [3:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic [15:0] err_cnt;

    sysmmu_axi_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .ID_WIDTH   (4),
        .MEM_AW     (10),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_beat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_resp_t;

    r_beat_t     r_sb[$];
    b_resp_t     b_sb[$];
    logic [63:0] mm [1024];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    int          exp_err;
    int          checks;
    int          errors;

    function automatic logic sig(input int sel);
        case (sel)
            0:       return s_awready;
            1:       return s_wready;
            2:       return s_bvalid;
            3:       return s_arready;
            4:       return s_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    // Called at a negedge; returns at the first negedge where the selected
    // signal is high, or reports a timeout.
    task automatic wait_high(input int sel, input string name, output logic ok);
        int n;
        n = 0;
        while (!sig(sel) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ok = sig(sel);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got 0 after %0d cycles, expected 1", name, TMO);
        end
    endtask

    task automatic check_err_cnt(input string name);
        checks++;
        if (err_cnt !== exp_err[15:0]) begin
            errors++;
            $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
        end
    endtask

    // Issue one write burst using wd[]/ws[]; wlast is driven from beat
    // wlast_from onward. The model is updated and the B response predicted.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input int wlast_from,
                               input int bready_delay);
        logic    bad;
        logic    err;
        logic    ok;
        logic [31:0] a;
        b_resp_t exp_b;
        b_resp_t got_b;
        bad = (size != 3'd3) || burst[1];
        err = bad;
        a   = addr & ~32'h7;
        for (int i = 0; i <= int'(len); i++) begin
            if ((i >= wlast_from) != (i == int'(len))) begin
                err = 1'b1;
                exp_err++;
            end
            if (!bad && a < WIN_END) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[i][b]) mm[a[12:3]][b*8 +: 8] = wd[i][b*8 +: 8];
                end
            end else begin
                err = 1'b1;
            end
            if (burst == INCR) a = a + 32'd8;
        end
        if (err) exp_err++;
        b_sb.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

        @(negedge clk);
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        wait_high(0, "awready", ok);
        if (!ok) begin s_awvalid = 1'b0; b_sb.delete(); return; end
        @(negedge clk);
        s_awvalid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i >= wlast_from); s_wvalid = 1'b1;
            wait_high(1, "wready", ok);
            if (!ok) begin s_wvalid = 1'b0; b_sb.delete(); return; end
            @(negedge clk);
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;

        wait_high(2, "bvalid", ok);
        if (!ok) begin b_sb.delete(); return; end
        repeat (bready_delay) @(negedge clk);
        exp_b = b_sb.pop_front();
        got_b = '{id: s_bid, resp: s_bresp};
        checks++;
        if (s_bvalid !== 1'b1 || got_b !== exp_b) begin
            errors++;
            $display("FAIL b_resp @%h: got valid=%b id=%h resp=%b, expected valid=1 id=%h resp=%b",
                     addr, s_bvalid, got_b.id, got_b.resp, exp_b.id, exp_b.resp);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_drop @%h: got bvalid=%b expected 0", addr, s_bvalid);
        end
    endtask

    // Issue one read burst; beat 0 is held with rready=0 for `stall` cycles.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst,
                              input logic [2:0] size, input int stall);
        logic    bad;
        logic    in_win;
        logic    ok;
        logic [31:0] a;
        r_beat_t exp_r;
        r_beat_t got_r;
        bad = (size != 3'd3) || burst[1];
        a   = addr & ~32'h7;
        for (int i = 0; i <= int'(len); i++) begin
            in_win = !bad && a < WIN_END;
            r_sb.push_back('{id: id, data: in_win ? mm[a[12:3]] : 64'h0,
                             resp: in_win ? 2'b00 : 2'b10, last: (i == int'(len))});
            if (!in_win) exp_err++;
            if (burst == INCR) a = a + 32'd8;
        end

        @(negedge clk);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        s_rready  = (stall == 0);
        wait_high(3, "arready", ok);
        if (!ok) begin s_arvalid = 1'b0; r_sb.delete(); return; end
        @(negedge clk);
        s_arvalid = 1'b0;
        // First rvalid appears two cycles after the AR handshake cycle
        checks++;
        if (s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_latency_early @%h: got rvalid=%b expected 0", addr, s_rvalid);
        end
        @(negedge clk);
        checks++;
        if (s_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL r_latency @%h: got rvalid=%b expected 1", addr, s_rvalid);
        end

        for (int i = 0; i <= int'(len); i++) begin
            wait_high(4, "rvalid", ok);
            if (!ok) begin r_sb.delete(); s_rready = 1'b0; return; end
            exp_r = r_sb.pop_front();
            got_r = '{id: s_rid, data: s_rdata, resp: s_rresp, last: s_rlast};
            checks++;
            if (got_r !== exp_r) begin
                errors++;
                $display("FAIL r_beat @%h beat %0d: got id=%h data=%h resp=%b last=%b, expected id=%h data=%h resp=%b last=%b",
                         addr, i, got_r.id, got_r.data, got_r.resp, got_r.last,
                         exp_r.id, exp_r.data, exp_r.resp, exp_r.last);
            end
            if (i == 0 && stall > 0) begin
                for (int c = 0; c < stall; c++) begin
                    @(negedge clk);
                    got_r = '{id: s_rid, data: s_rdata, resp: s_rresp, last: s_rlast};
                    checks++;
                    if (s_rvalid !== 1'b1 || got_r !== exp_r) begin
                        errors++;
                        $display("FAIL r_stall_hold cycle %0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                                 c, s_rvalid, got_r.data, got_r.last, exp_r.data, exp_r.last);
                    end
                end
                s_rready = 1'b1;
            end
            @(negedge clk);
        end
        s_rready = 1'b0;
        checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL r_done @%h: got rvalid=%b arready=%b, expected rvalid=0 arready=1",
                     addr, s_rvalid, s_arready);
        end
    endtask

    task automatic fill(input logic [63:0] seed, input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = seed + 64'(i) * 64'h0101_0101_0101_0101;
            ws[i] = 8'hFF;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bresp, s_rresp,
             s_rlast, s_rdata, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got awr=%b wr=%b bv=%b arr=%b rv=%b bresp=%b rresp=%b rlast=%b rdata=%h err=%0d, expected all 0",
                     s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bresp, s_rresp,
                     s_rlast, s_rdata, err_cnt);
        end
        sys_rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        checks++;
        if (s_awready !== 1'b1 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got awready=%b arready=%b expected 1 1", s_awready, s_arready);
        end
    endtask

    task automatic test_incr_burst();
        fill(64'hD000_0000_0000_0000, 4);
        write_burst(4'h1, 32'h40, 8'd3, INCR, 3'd3, 3, 3);
        read_burst(4'h2, 32'h40, 8'd3, INCR, 3'd3, 0);
        check_err_cnt("incr");
    endtask

    task automatic test_byte_strobe();
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        write_burst(4'h3, 32'h100, 8'd0, INCR, 3'd3, 0, 0);
        wd[0] = 64'h0000_0000_0000_0011; ws[0] = 8'h01;
        write_burst(4'h3, 32'h100, 8'd0, INCR, 3'd3, 0, 0);
        read_burst(4'h4, 32'h100, 8'd0, INCR, 3'd3, 0);
        check_err_cnt("strobe");
    endtask

    task automatic test_fixed_burst();
        fill(64'h0F0F_0000_1234_0000, 3);
        write_burst(4'h5, 32'h200, 8'd2, FIXED, 3'd3, 2, 0);
        read_burst(4'h5, 32'h200, 8'd1, FIXED, 3'd3, 0);
        read_burst(4'h5, 32'h208, 8'd0, INCR, 3'd3, 0);
        check_err_cnt("fixed");
    endtask

    task automatic test_window_edge();
        wd[0] = 64'h5A5A_0000_0000_0A0A; ws[0] = 8'hFF;
        write_burst(4'h6, 32'h0, 8'd0, INCR, 3'd3, 0, 0);
        fill(64'hE000_0000_0000_00E0, 2);
        write_burst(4'h7, 32'h1FF8, 8'd1, INCR, 3'd3, 1, 0);
        read_burst(4'h8, 32'h0, 8'd0, INCR, 3'd3, 0);
        read_burst(4'h9, 32'h1FF8, 8'd1, INCR, 3'd3, 0);
        check_err_cnt("window");
        // Beat 0 at the top of the address space is out of window; beat 1
        // wraps to address 0 and is written.
        fill(64'hC000_0000_0000_00C0, 2);
        write_burst(4'hA, 32'hFFFF_FFF8, 8'd1, INCR, 3'd3, 1, 0);
        read_burst(4'hA, 32'hFFFF_FFF8, 8'd1, INCR, 3'd3, 0);
        check_err_cnt("addr_wrap");
    endtask

    task automatic test_rready_stall();
        read_burst(4'hB, 32'h40, 8'd3, INCR, 3'd3, 10);
        check_err_cnt("stall");
    endtask

    task automatic test_wlast_mismatch();
        fill(64'h7700_0000_0000_0077, 3);
        write_burst(4'hC, 32'h500, 8'd2, INCR, 3'd3, 1, 0);
        check_err_cnt("wlast_early");
        fill(64'h6600_0000_0000_0066, 2);
        write_burst(4'hC, 32'h518, 8'd1, INCR, 3'd3, 99, 0);
        check_err_cnt("wlast_missing");
        read_burst(4'hD, 32'h500, 8'd4, INCR, 3'd3, 0);
        check_err_cnt("wlast_readback");
    endtask

    task automatic test_illegal();
        fill(64'hBAD0_0000_0000_0BAD, 4);
        write_burst(4'hE, 32'h40, 8'd3, WRAP, 3'd3, 3, 0);
        write_burst(4'hE, 32'h60, 8'd0, INCR, 3'd2, 0, 0);
        read_burst(4'hF, 32'h40, 8'd3, INCR, 3'd3, 0);
        read_burst(4'hF, 32'h40, 8'd1, INCR, 3'd2, 0);
        read_burst(4'hF, 32'h40, 8'd1, 2'b11, 3'd3, 0);
        check_err_cnt("illegal");
    endtask

    task automatic test_reset_mid_read();
        logic ok;
        fill(64'hA5A5_0000_0000_1000, 8);
        write_burst(4'h1, 32'h300, 8'd7, INCR, 3'd3, 7, 0);
        @(negedge clk);
        s_arid = 4'h2; s_araddr = 32'h300; s_arlen = 8'd7; s_arsize = 3'd3; s_arburst = INCR;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        wait_high(3, "arready", ok);
        if (!ok) begin s_arvalid = 1'b0; s_rready = 1'b0; return; end
        @(negedge clk);
        s_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_high(4, "rvalid", ok);
            if (!ok) begin s_rready = 1'b0; return; end
            checks++;
            if (s_rdata !== mm[10'h060 + 10'(i)]) begin
                errors++;
                $display("FAIL rst_pre_beat %0d: got %h expected %h", i, s_rdata, mm[10'h060 + 10'(i)]);
            end
            @(negedge clk);
        end
        wait_high(4, "rvalid", ok);
        if (!ok) begin s_rready = 1'b0; return; end
        sys_rst  = 1'b1;
        s_rready = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_rvalid, s_arready, s_awready, err_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid_burst: got rvalid=%b arready=%b awready=%b err=%0d, expected all 0",
                     s_rvalid, s_arready, s_awready, err_cnt);
        end
        sys_rst = 1'b0;
        exp_err = 0;
        read_burst(4'h3, 32'h300, 8'd1, INCR, 3'd3, 0);
        check_err_cnt("post_reset");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_err   = 0;
        sys_rst   = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;

        test_reset();
        test_incr_burst();
        test_byte_strobe();
        test_fixed_burst();
        test_window_edge();
        test_rready_stall();
        test_wlast_mismatch();
        test_illegal();
        test_reset_mid_read();

        checks++;
        if (r_sb.size() != 0 || b_sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d R and %0d B left, expected 0 0", r_sb.size(), b_sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
